// File: rtl/se_sram_pkg.sv
// se_sram_pkg
// Shared definitions for initiators of the single-port synchronous SRAM
// (se_sram_srw).
//   SE_SRAM_READ_LATENCY : enabled edges from the SRAM sampling a read
//                          command to its data appearing on data_out
//   se_sram_req_t        : request record (rnw, address, write_data) at
//                          the default SRAM geometry
package se_sram_pkg;

    localparam int SE_SRAM_READ_LATENCY  = 1;
    localparam int SE_SRAM_ADDRESS_WIDTH = 16;
    localparam int SE_SRAM_DATA_WIDTH    = 8;

    typedef struct packed {
        logic                             rnw;
        logic [SE_SRAM_ADDRESS_WIDTH-1:0] address;
        logic [SE_SRAM_DATA_WIDTH-1:0]    write_data;
    } se_sram_req_t;

endpackage

// File: rtl/se_sram_rsp_fifo.sv
// se_sram_rsp_fifo
// Synchronous response FIFO for the SRAM master.
// Ports:
//   sram_clock  in   clock
//   int_reset   in   synchronous active-high reset (honoured on enabled edges)
//   enable      in   gates every state update
//   push        in   write push_data on an enabled edge
//   push_data   in   data to store
//   pop         in   advance the head on an enabled edge (caller guarantees non-empty)
//   head_data   out  oldest entry, 0 when empty
//   count       out  number of stored entries
// depth must be a power of two so the pointers wrap naturally.
module se_sram_rsp_fifo #(
    parameter int data_width = 8,
    parameter int depth      = 4
) (
    input  logic                    sram_clock,
    input  logic                    int_reset,
    input  logic                    enable,
    input  logic                    push,
    input  logic [data_width-1:0]   push_data,
    input  logic                    pop,
    output logic [data_width-1:0]   head_data,
    output logic [$clog2(depth):0]  count
);

    localparam int ptr_width = $clog2(depth);

    logic [data_width-1:0] mem [depth];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;

    always_ff @(posedge sram_clock) begin
        if (enable) begin
            if (int_reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage is not reset; an empty FIFO never exposes it.
    always_ff @(posedge sram_clock) begin
        if (enable && !int_reset && push) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/se_sram_srw_master.sv
// se_sram_srw_master
// Initiator for a single-port synchronous SRAM (se_sram_srw). Requests are
// accepted on a valid/ready handshake and turned into registered SRAM
// commands; read data is captured one edge after the SRAM samples the
// command and returned in issue order through a credit-protected FIFO.
// Ports:
//   sram_clock, sram_clock__enable  clock shared with the SRAM and its enable
//   int_reset                       synchronous active-high reset
//   req_*                           request channel (valid/ready)
//   sram_*                          registered SRAM command, sram_data_out back
//   rsp_*                           response channel (valid/ready), data 0 when empty
//   idle                            nothing issued, nothing in flight, FIFO empty
module se_sram_srw_master
    import se_sram_pkg::*;
#(
    parameter int address_width  = 16,
    parameter int data_width     = 8,
    parameter int rsp_fifo_depth = 4
) (
    input  logic                     sram_clock,
    input  logic                     int_reset,
    input  logic                     sram_clock__enable,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_read_not_write,
    input  logic [address_width-1:0] req_address,
    input  logic [data_width-1:0]    req_write_data,
    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic [address_width-1:0] sram_address,
    output logic [data_width-1:0]    sram_write_data,
    input  logic [data_width-1:0]    sram_data_out,
    output logic                     rsp_valid,
    output logic [data_width-1:0]    rsp_data,
    input  logic                     rsp_ready,
    output logic                     idle
);

    localparam int count_width = $clog2(rsp_fifo_depth) + 1;
    localparam int used_width  = count_width + SE_SRAM_READ_LATENCY + 1;

    logic [count_width-1:0]          fifo_count;
    logic [SE_SRAM_READ_LATENCY-1:0] capture_pipe;
    logic [SE_SRAM_READ_LATENCY:0]   capture_shift;
    logic [used_width-1:0]           used;
    logic                            issue_read;
    logic                            accept;
    logic                            push;
    logic                            pop;

    // A read command on the pins is sampled by the SRAM at the coming edge;
    // its data emerges SE_SRAM_READ_LATENCY edges later, which is when the
    // top of the shift register says to push.
    assign issue_read    = sram_select && sram_read_not_write;
    assign capture_shift = {capture_pipe, issue_read};
    assign push          = capture_shift[SE_SRAM_READ_LATENCY];

    // Every read between acceptance and pop holds one FIFO credit, so the
    // FIFO can never overflow. Depends on registered state only.
    assign used = used_width'(fifo_count)
                + used_width'(issue_read)
                + used_width'($countones(capture_pipe));

    assign req_ready = used < used_width'(rsp_fifo_depth);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = fifo_count != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign idle      = !sram_select && (capture_pipe == '0) && !rsp_valid;

    always_ff @(posedge sram_clock) begin
        if (sram_clock__enable) begin
            if (int_reset) begin
                sram_select         <= 1'b0;
                sram_read_not_write <= 1'b1;
                sram_address        <= '0;
                sram_write_data     <= '0;
                capture_pipe        <= '0;
            end else begin
                sram_select  <= accept;
                capture_pipe <= capture_shift[SE_SRAM_READ_LATENCY-1:0];
                if (accept) begin
                    sram_read_not_write <= req_read_not_write;
                    sram_address        <= req_address;
                    sram_write_data     <= req_write_data;
                end
            end
        end
    end

    se_sram_rsp_fifo #(
        .data_width (data_width),
        .depth      (rsp_fifo_depth)
    ) u_rsp_fifo (
        .sram_clock (sram_clock),
        .int_reset  (int_reset),
        .enable     (sram_clock__enable),
        .push       (push),
        .push_data  (sram_data_out),
        .pop        (pop),
        .head_data  (rsp_data),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_se_sram_srw_master.sv
module tb_se_sram_srw_master;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int VW    = 2 + DW + 2 + 1 + AW + DW;

    logic          sram_clock = 1'b0;
    logic          int_reset;
    logic          sram_clock__enable;
    logic          req_valid;
    logic          req_ready;
    logic          req_read_not_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_write_data;
    logic          sram_select;
    logic          sram_read_not_write;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_data_out;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready;
    logic          idle;

    int checks   = 0;
    int failures = 0;

    se_sram_srw_master #(
        .address_width  (AW),
        .data_width     (DW),
        .rsp_fifo_depth (DEPTH)
    ) dut (
        .sram_clock          (sram_clock),
        .int_reset           (int_reset),
        .sram_clock__enable  (sram_clock__enable),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_read_not_write  (req_read_not_write),
        .req_address         (req_address),
        .req_write_data      (req_write_data),
        .sram_select         (sram_select),
        .sram_read_not_write (sram_read_not_write),
        .sram_address        (sram_address),
        .sram_write_data     (sram_write_data),
        .sram_data_out       (sram_data_out),
        .rsp_valid           (rsp_valid),
        .rsp_data            (rsp_data),
        .rsp_ready           (rsp_ready),
        .idle                (idle)
    );

    always #5 sram_clock = ~sram_clock;

    // Behavioural single-port SRAM: write on the command edge, registered read.
    logic [DW-1:0] sram_mem [0:65535];
    always @(posedge sram_clock) begin
        if (sram_clock__enable && sram_select) begin
            if (sram_read_not_write) sram_data_out <= sram_mem[sram_address];
            else                     sram_mem[sram_address] <= sram_write_data;
        end
    end

    // Reference model: outstanding reads (accepted, not yet popped) in
    // issue order, each visible as a response 3 enabled edges after acceptance.
    typedef struct {
        logic [DW-1:0] data;
        int            ready_at;
    } exp_rsp_t;

    exp_rsp_t      exp_q[$];
    logic [DW-1:0] ref_mem [0:65535];
    int            ecount     = 0;
    bit            cmd_active = 1'b0;
    logic          cmd_rnw    = 1'b1;
    logic [AW-1:0] cmd_addr   = '0;
    logic [DW-1:0] cmd_wdata  = '0;

    function automatic bit head_visible();
        return exp_q.size() > 0 && exp_q[0].ready_at <= ecount;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic          v;
        logic [DW-1:0] d;
        v = head_visible();
        d = v ? exp_q[0].data : '0;
        return {exp_q.size() < DEPTH, v, d, cmd_active,
                !cmd_active && exp_q.size() == 0, cmd_rnw, cmd_addr, cmd_wdata};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {req_ready, rsp_valid, rsp_data, sram_select, idle,
                sram_read_not_write, sram_address, sram_write_data};
    endfunction

    // Advance one clock and update the model with what that edge should do.
    task automatic tick();
        bit            en, rst, acc, pop;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        en   = sram_clock__enable;
        rst  = int_reset;
        acc  = en && !rst && req_valid && exp_q.size() < DEPTH;
        pop  = en && !rst && head_visible() && rsp_ready;
        rnw  = req_read_not_write;
        addr = req_address;
        wd   = req_write_data;
        @(posedge sram_clock);
        #1;
        if (en) begin
            if (rst) begin
                exp_q.delete();
                cmd_active = 1'b0;
                cmd_rnw    = 1'b1;
                cmd_addr   = '0;
                cmd_wdata  = '0;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (acc) begin
                    cmd_rnw   = rnw;
                    cmd_addr  = addr;
                    cmd_wdata = wd;
                    if (rnw) exp_q.push_back('{ref_mem[addr], ecount + 3});
                    else     ref_mem[addr] = wd;
                end
                cmd_active = acc;
            end
            ecount++;
        end
    endtask

    task automatic preload();
        for (int a = 0; a < 16; a++) begin
            sram_mem[a] = DW'(a + 'h40);
            ref_mem[a]  = DW'(a + 'h40);
        end
    endtask

    task automatic test_reset();
        int_reset          = 1'b1;
        sram_clock__enable = 1'b1;
        req_valid          = 1'b0;
        req_read_not_write = 1'b0;
        req_address        = '0;
        req_write_data     = '0;
        rsp_ready          = 1'b0;
        tick();
        tick();
        checks++;
        if (observed() !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", observed(),
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00});
        end
        int_reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [3:0] vld;
        rsp_ready          = 1'b1;
        req_valid          = 1'b1;
        req_read_not_write = 1'b0;
        req_address        = 16'h0010;
        req_write_data     = 8'hA5;
        tick();
        checks++;
        if ({sram_select, sram_read_not_write, sram_address, sram_write_data} !== {1'b1, 1'b0, 16'h0010, 8'hA5}) begin
            failures++;
            $display("FAIL wr_cmd got=%b/%b/%h/%h want=1/0/0010/a5",
                     sram_select, sram_read_not_write, sram_address, sram_write_data);
        end
        req_read_not_write = 1'b1;
        req_write_data     = 8'h00;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({sram_select, sram_read_not_write, sram_address} !== {1'b1, 1'b1, 16'h0010}) begin
            failures++;
            $display("FAIL rd_cmd got=%b/%b/%h want=1/1/0010", sram_select, sram_read_not_write, sram_address);
        end
        vld[0] = rsp_valid;
        tick();
        checks++;
        if (sram_select !== 1'b0) begin
            failures++;
            $display("FAIL select_pulse got=%b want=0", sram_select);
        end
        vld[1] = rsp_valid;
        tick();
        vld[2] = rsp_valid;
        checks++;
        if ({vld[2:0], rsp_data} !== {3'b100, 8'hA5}) begin
            failures++;
            $display("FAIL rd_latency got valid=%b data=%h want valid=100 data=a5", vld[2:0], rsp_data);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, idle} !== {1'b0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL idle_after got=%b/%h/%b want=0/00/1", rsp_valid, rsp_data, idle);
        end
        checks++;
        if (observed() !== exp_vec()) begin
            failures++;
            $display("FAIL write_read_model got=%h want=%h", observed(), exp_vec());
        end
    endtask

    task automatic test_burst(input bit hold_ready, input bit gate, input string name,
                              output int first_rsp, output int last_rsp);
        int issued = 0;
        int got    = 0;
        int start  = ecount;
        first_rsp = -1;
        last_rsp  = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (issued == 8 && exp_q.size() == 0 && !cmd_active) break;
            sram_clock__enable = !(gate && cyc >= 3 && cyc <= 5);
            req_valid          = issued < 8;
            req_read_not_write = 1'b1;
            req_address        = AW'(issued);
            req_write_data     = DW'($urandom);
            rsp_ready          = hold_ready || cyc >= 12;
            if (!hold_ready && !gate && (cyc == 3 || cyc == 4)) begin
                checks++;
                if (req_ready !== (cyc == 3)) begin
                    failures++;
                    $display("FAIL %s credit_stall cyc=%0d got=%b want=%b", name, cyc, req_ready, cyc == 3);
                end
            end
            if (hold_ready && !gate) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s ready_held cyc=%0d got=%b want=1", name, cyc, req_ready);
                end
            end
            if (sram_clock__enable && req_valid && exp_q.size() < DEPTH) issued++;
            if (sram_clock__enable && head_visible() && rsp_ready) begin
                checks++;
                if (rsp_data !== DW'('h40 + got)) begin
                    failures++;
                    $display("FAIL %s order got=%h want=%h", name, rsp_data, DW'('h40 + got));
                end
                if (got == 0) first_rsp = ecount - start;
                last_rsp = ecount - start;
                got++;
            end
            tick();
            checks++;
            if (observed() !== exp_vec()) begin
                failures++;
                $display("FAIL %s model cyc=%0d got=%h want=%h", name, cyc, observed(), exp_vec());
            end
        end
        req_valid          = 1'b0;
        sram_clock__enable = 1'b1;
        checks++;
        if (got != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s count got=%0d pending=%0d want=8/0", name, got, exp_q.size());
        end
        if (hold_ready) begin
            checks++;
            if (first_rsp != 3 || last_rsp - first_rsp != 7) begin
                failures++;
                $display("FAIL %s timing first=%0d last=%0d want=3/10", name, first_rsp, last_rsp);
            end
        end
    endtask

    task automatic test_gating_equiv(input int f0, input int l0, input int f1, input int l1);
        checks++;
        if (f1 != f0 || l1 != l0) begin
            failures++;
            $display("FAIL gate_equiv got=%0d/%0d want=%0d/%0d", f1, l1, f0, l0);
        end
    endtask

    task automatic test_reset_inflight();
        rsp_ready          = 1'b0;
        req_read_not_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid   = 1'b1;
            req_address = AW'(i);
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (exp_q.size() != 3 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL inflight_setup got valid=%b pending=%0d want=1/3", rsp_valid, exp_q.size());
        end
        int_reset = 1'b1;
        tick();
        int_reset = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data, req_ready, sram_select, idle} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL inflight_reset got=%b/%h/%b/%b/%b want=0/00/1/0/1",
                     rsp_valid, rsp_data, req_ready, sram_select, idle);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || observed() !== exp_vec()) begin
                failures++;
                $display("FAIL stale_rsp cyc=%0d got=%h want=%h", i, observed(), exp_vec());
            end
        end
    endtask

    task automatic test_push_pop();
        int issued = 0;
        req_read_not_write = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            req_valid   = issued < 4;
            req_address = AW'(issued);
            rsp_ready   = cyc >= 5;
            if (cyc == 5) begin
                checks++;
                if (exp_q.size() != 4 || req_ready !== 1'b0 || rsp_data !== 8'h40) begin
                    failures++;
                    $display("FAIL pp_setup got ready=%b data=%h want=0/40", req_ready, rsp_data);
                end
            end
            if (req_valid && exp_q.size() < DEPTH) issued++;
            tick();
            if (cyc == 5) begin
                checks++;
                if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 8'h41, 1'b1}) begin
                    failures++;
                    $display("FAIL pp_advance got=%b/%h/%b want=1/41/1", rsp_valid, rsp_data, req_ready);
                end
            end
            checks++;
            if (observed() !== exp_vec()) begin
                failures++;
                $display("FAIL push_pop model cyc=%0d got=%h want=%h", cyc, observed(), exp_vec());
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            sram_clock__enable = $urandom_range(0, 9) != 0;
            int_reset          = $urandom_range(0, 99) == 0;
            req_valid          = $urandom_range(0, 9) < 6;
            req_read_not_write = $urandom_range(0, 1) == 1;
            req_address        = AW'($urandom_range(0, 7));
            req_write_data     = DW'($urandom);
            rsp_ready          = $urandom_range(0, 9) < 7;
            tick();
            checks++;
            if (observed() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, observed(), exp_vec());
            end
        end
        int_reset          = 1'b0;
        sram_clock__enable = 1'b1;
        req_valid          = 1'b0;
        rsp_ready          = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (idle !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain got idle=%b pending=%0d want=1/0", idle, exp_q.size());
        end
    endtask

    initial begin
        int f0, l0, f1, l1, fx, lx;
        preload();
        test_reset();
        test_write_read();
        test_burst(1'b1, 1'b0, "burst_ready", f0, l0);
        test_burst(1'b0, 1'b0, "burst_stall", fx, lx);
        test_burst(1'b1, 1'b1, "burst_gated", f1, l1);
        test_gating_equiv(f0, l0, f1, l1);
        test_reset_inflight();
        test_push_pop();
        for (int i = 0; i < 6; i++) tick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
